// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared definitions for the GPR writeback port: default widths and requester IDs.
package gpr_wb_arbiter_pkg;

    localparam int GPU_DDATA_WIDTH = 64;

    localparam int GPR_DW   = GPU_DDATA_WIDTH;
    localparam int GPR_AW   = 5;
    localparam int GPR_NREG = 32;
    localparam int GPR_NREQ = 3;

    typedef enum int unsigned {
        REQ_ALU  = 0,
        REQ_LSU  = 1,
        REQ_LONG = 2
    } req_id_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin arbiter; the search starts at the pointer, which moves past each winner.
module rr_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREQ = GPR_NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

    localparam int          PW     = ptr_width(NREQ);
    localparam int unsigned NREQ_U = NREQ;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;
    int unsigned   scan_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            scan_idx = (32'(ptr) + k) % NREQ_U;
            if (!found && req[scan_idx]) begin
                found            = 1'b1;
                grant[scan_idx]  = 1'b1;
                grant_idx        = PW'(scan_idx);
            end
        end
    end

    // Every grant is a transfer: the port has no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between writeback sources and tracks pending writes
// in a per-register busy scoreboard for ID hazard checks.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int DW   = GPR_DW,
    parameter int NREQ = GPR_NREQ,
    parameter int NREG = GPR_NREG,
    parameter int AW   = GPR_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               gpr_write,
    output logic [AW-1:0]      rd_index,
    output logic [DW-1:0]      data_rd,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rd,
    input  logic [AW-1:0]      rs1_index,
    input  logic [AW-1:0]      rs2_index,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic               rd_busy,
    input  logic               flush
);

    localparam int unsigned NREQ_U = NREQ;
    localparam int unsigned NREG_U = NREG;

    logic [NREQ-1:0] grant;
    logic            any_grant;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // x0 results are consumed and latched but never raise gpr_write.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_write <= 1'b0;
            rd_index  <= '0;
            data_rd   <= '0;
        end else if (any_grant) begin
            gpr_write <= (sel_rd != '0);
            rd_index  <= sel_rd;
            data_rd   <= sel_data;
        end else begin
            gpr_write <= 1'b0;
        end
    end

    // A new producer issuing to the register being retired keeps it busy.
    always_comb begin
        sb_next = '0;
        if (!flush) begin
            for (int unsigned r = 1; r < NREG_U; r++) begin
                sb_next[r] = (sb[r] && !(gpr_write && rd_index == AW'(r)))
                           || (issue_valid && issue_rd == AW'(r));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    assign rs1_busy = sb[rs1_index];
    assign rs2_busy = sb[rs2_index];
    assign rd_busy  = sb[issue_rd];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a cycle-level reference model and literal spot checks.
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    localparam int DW   = 64;
    localparam int NREQ = 3;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic               gpr_write;
    logic [AW-1:0]      rd_index;
    logic [DW-1:0]      data_rd;
    logic               issue_valid;
    logic [AW-1:0]      issue_rd;
    logic [AW-1:0]      rs1_index;
    logic [AW-1:0]      rs2_index;
    logic               rs1_busy;
    logic               rs2_busy;
    logic               rd_busy;
    logic               flush;

    int checks   = 0;
    int failures = 0;

    gpr_wb_arbiter #(.DW(DW), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .gpr_write   (gpr_write),
        .rd_index    (rd_index),
        .data_rd     (data_rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_index   (rs1_index),
        .rs2_index   (rs2_index),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending-write flag, busy set, and rotating priority start.
    int          m_ptr;
    bit [31:0]   m_sb;
    bit          m_wr;
    bit [AW-1:0] m_rd;
    bit [DW-1:0] m_data;
    bit          live = 1'b0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int g;
        if (rst) begin
            m_ptr  = 0;
            m_sb   = '0;
            m_wr   = 1'b0;
            m_rd   = '0;
            m_data = '0;
            live   = 1'b1;
        end else if (live) begin
            g = pick(req_valid, m_ptr);
            if (m_wr) m_sb[m_rd] = 1'b0;
            if (flush) m_sb = '0;
            else if (issue_valid && issue_rd != 0) m_sb[issue_rd] = 1'b1;
            if (g >= 0) begin
                m_rd   = req_rd[g*AW +: AW];
                m_data = req_data[g*DW +: DW];
                m_wr   = (m_rd != 0);
                m_ptr  = (g + 1) % NREQ;
            end else begin
                m_wr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        logic [NREQ-1:0] er;
        if (live) begin
            g  = pick(req_valid, m_ptr);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("m_req_ready", req_ready, er);
            chk("m_gpr_write", gpr_write, m_wr);
            chk("m_rd_index", rd_index, m_rd);
            chk("m_data_rd", data_rd, m_data);
            chk("m_rs1_busy", rs1_busy, m_sb[rs1_index]);
            chk("m_rs2_busy", rs2_busy, m_sb[rs2_index]);
            chk("m_rd_busy", rd_busy, m_sb[issue_rd]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_rd[i*AW +: AW]    = rd;
        req_data[i*DW +: DW]  = d;
    endtask

    initial begin : stim
        logic [NREQ-1:0] e;
        rst         = 1'b1;
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_index   = 5'd5;
        rs2_index   = 5'd9;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_gpr_write", gpr_write, 0);
        chk("rst_rd_index", rd_index, 0);
        chk("rst_data_rd", data_rd, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rs1_busy", rs1_busy, 0);
        tick();

        // single requester
        set_req(REQ_LSU, 1'b1, 5'd7, 64'hDEAD);
        @(negedge clk);
        chk("single_ready", req_ready, 3'b010);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("single_write", gpr_write, 1);
        chk("single_rd", rd_index, 7);
        chk("single_data", data_rd, 64'hDEAD);
        tick();
        @(negedge clk);
        chk("single_write_off", gpr_write, 0);
        tick();

        // fairness from a freshly reset pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(REQ_ALU,  1'b1, 5'd10, 64'hA0);
        set_req(REQ_LSU,  1'b1, 5'd11, 64'hA1);
        set_req(REQ_LONG, 1'b1, 5'd12, 64'hA2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e = '0;
            e[c % 3] = 1'b1;
            chk("fair_grant", req_ready, e);
            if (c > 0) begin
                chk("fair_write", gpr_write, 1);
                chk("fair_rd", rd_index, 10 + ((c - 1) % 3));
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("fair_last_rd", rd_index, 12);
        tick();

        // scoreboard set and clear on rd=5
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        rs1_index   = 5'd5;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("sb5_set", rs1_busy, 1);
        tick();
        set_req(REQ_ALU, 1'b1, 5'd5, 64'h55);
        @(negedge clk);
        chk("sb5_hold", rs1_busy, 1);
        tick();
        set_req(REQ_ALU, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("sb5_wr", gpr_write, 1);
        chk("sb5_busy_wr_cycle", rs1_busy, 1);
        tick();
        @(negedge clk);
        chk("sb5_cleared", rs1_busy, 0);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1_index   = 5'd0;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("sb0_never", rs1_busy, 0);
        tick();

        // set/clear collision on rd=9
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        set_req(REQ_LSU, 1'b1, 5'd9, 64'h99);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 64'h0);
        issue_valid = 1'b1;
        @(negedge clk);
        chk("coll_write", gpr_write, 1);
        chk("coll_rd", rd_index, 9);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("coll_busy", rd_busy, 1);
        tick();

        // x0 write from the long-latency requester
        set_req(REQ_LONG, 1'b1, 5'd0, 64'h77);
        @(negedge clk);
        chk("x0_ready", req_ready, 3'b100);
        tick();
        set_req(REQ_LONG, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("x0_no_write", gpr_write, 0);
        chk("x0_data_loaded", data_rd, 64'h77);
        tick();

        // flush clears everything, including a coincident issue
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_rd    = 5'd4;
        tick();
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        rs1_index   = 5'd3;
        rs2_index   = 5'd4;
        @(negedge clk);
        chk("pre_flush_rs1", rs1_busy, 1);
        chk("pre_flush_rs2", rs2_busy, 1);
        chk("pre_flush_rd", rd_busy, 1);
        tick();
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        set_req(REQ_ALU, 1'b1, 5'd14, 64'h1414);
        @(negedge clk);
        chk("flush_arb_continues", req_ready, 3'b001);
        tick();
        flush       = 1'b0;
        issue_valid = 1'b0;
        set_req(REQ_ALU, 1'b0, 5'd0, 64'h0);
        issue_rd    = 5'd12;
        @(negedge clk);
        chk("flush_rs1", rs1_busy, 0);
        chk("flush_rs2", rs2_busy, 0);
        chk("flush_rd12", rd_busy, 0);
        chk("flush_write_kept", gpr_write, 1);
        #1 issue_rd = 5'd6;
        #1 chk("flush_rd6", rd_busy, 0);
        issue_rd  = 5'd9;
        #1 chk("flush_rd9", rd_busy, 0);
        tick();

        // reset while a write is in the stage
        set_req(REQ_LSU, 1'b1, 5'd20, 64'h2020);
        @(negedge clk);
        chk("mid_ready", req_ready, 3'b010);
        tick();
        set_req(REQ_LSU, 1'b0, 5'd0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_write_before", gpr_write, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_write_dropped", gpr_write, 0);
        chk("mid_rd_reset", rd_index, 0);
        chk("mid_data_reset", data_rd, 0);
        tick();
        set_req(REQ_ALU,  1'b1, 5'd1, 64'h1);
        set_req(REQ_LSU,  1'b1, 5'd2, 64'h2);
        set_req(REQ_LONG, 1'b1, 5'd3, 64'h3);
        @(negedge clk);
        chk("mid_ptr_zero", req_ready, 3'b001);
        tick();
        req_valid = '0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
